// File: rtl/pc_unit.sv
// Program counter stage: boot cycle, stall, one-cycle flush after taken branches.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int Psize     = 6,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [Psize-1:0] Branchaddr,
  input  logic             stall,
  input  logic             call,
  input  logic             ret,
  output logic [Psize-1:0] PCout,
  output logic             fetch_valid,
  output logic             flush,
  output logic             ras_err
);

  localparam logic [Psize-1:0] RST_PC = RESET_VEC[Psize-1:0];
  localparam logic [Psize-1:0] PC_ONE = {{(Psize-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t           state_q;
  logic [Psize-1:0] pc_q, pc_d;
  logic             fv_q, flush_q;
  logic             taken_d;
  logic             advance;

  // Controls are honoured on any non-boot edge where stall is low.
  assign advance = (state_q != BOOT) && !stall;

`ifdef PC_RAS_EN
  localparam int SPW = $clog2(RAS_DEPTH);
  localparam logic [SPW-1:0] SP_ONE   = {{(SPW-1){1'b0}}, 1'b1};
  localparam logic [SPW:0]   CNT_ONE  = {{SPW{1'b0}}, 1'b1};
  localparam logic [SPW:0]   CNT_FULL = RAS_DEPTH[SPW:0];

  logic [Psize-1:0] stack_q [RAS_DEPTH];
  logic [SPW-1:0]   sp_q, sp_dec;
  logic [SPW:0]     cnt_q;
  logic             err_q;
  logic             push_d, pop_d, uflow_d;

  assign sp_dec = sp_q - SP_ONE;
`endif

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
`ifdef PC_RAS_EN
    push_d  = 1'b0;
    pop_d   = 1'b0;
    uflow_d = 1'b0;
    if (ret) begin
      taken_d = 1'b1;
      if (cnt_q == '0) begin
        pc_d    = RST_PC;
        uflow_d = 1'b1;
      end else begin
        pc_d  = stack_q[sp_dec];
        pop_d = 1'b1;
      end
    end else if (call) begin
      taken_d = 1'b1;
      push_d  = 1'b1;
      pc_d    = Branchaddr;
    end
`else
    if (call) begin
      taken_d = 1'b1;
      pc_d    = Branchaddr;
    end
`endif
    else if (PCabsbranch) begin
      taken_d = 1'b1;
      pc_d    = Branchaddr;
    end else if (PCrelbranch) begin
      // Same-width add is the sign-extended add modulo 2^Psize.
      taken_d = 1'b1;
      pc_d    = pc_q + Branchaddr;
    end else if (PCincr) begin
      pc_d = pc_q + PC_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RST_PC;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          fv_q    <= 1'b1;
          flush_q <= 1'b0;
        end
        RUN, STALL: begin
          if (stall) begin
            state_q <= STALL;
            flush_q <= 1'b0;
          end else begin
            state_q <= RUN;
            pc_q    <= pc_d;
            flush_q <= taken_d;
          end
        end
        default: begin
          state_q <= BOOT;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_RAS_EN
  // Circular stack: a push when full overwrites the oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else if (advance) begin
      if (push_d) begin
        stack_q[sp_q] <= pc_q + PC_ONE;
        sp_q          <= sp_q + SP_ONE;
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + CNT_ONE;
      end else if (pop_d) begin
        sp_q  <= sp_dec;
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (uflow_d) err_q <= 1'b1;
    end
  end

  assign ras_err = err_q;
`else
  logic unused_ret;
  assign unused_ret = ret;
  assign ras_err    = 1'b0;
`endif

  assign PCout       = pc_q;
  assign fetch_valid = fv_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver queues expected outputs, negedge monitor checks them.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       PCincr = 1'b0, PCabsbranch = 1'b0, PCrelbranch = 1'b0;
  logic       stall = 1'b0, call = 1'b0, ret = 1'b0;
  logic [5:0] Branchaddr = '0;
  logic [5:0] PCout;
  logic       fetch_valid, flush, ras_err;

  typedef struct packed {
    logic [5:0] pc;
    logic       fv;
    logic       fl;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] C_INC = 6'b100000;
  localparam logic [5:0] C_ABS = 6'b010000;
  localparam logic [5:0] C_REL = 6'b001000;
  localparam logic [5:0] C_STL = 6'b000100;
  localparam logic [5:0] C_CAL = 6'b000010;
  localparam logic [5:0] C_RET = 6'b000001;
  localparam logic [5:0] C_NONE = 6'b000000;

  pc_unit dut (
    .clk(clk), .reset_n(reset_n),
    .PCincr(PCincr), .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch),
    .Branchaddr(Branchaddr), .stall(stall), .call(call), .ret(ret),
    .PCout(PCout), .fetch_valid(fetch_valid), .flush(flush), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({PCout, fetch_valid, flush, ras_err} !== e) begin
        errors++;
        $display("FAIL out_chk #%0d: got pc=%0d fv=%0b flush=%0b err=%0b, want pc=%0d fv=%0b flush=%0b err=%0b",
                 checks, PCout, fetch_valid, flush, ras_err, e.pc, e.fv, e.fl, e.er);
      end
    end
  end

  task automatic push_exp(input logic [5:0] pc, input logic fv, input logic fl, input logic er);
    exp_t e;
    e.pc = pc; e.fv = fv; e.fl = fl; e.er = er;
    exp_q.push_back(e);
  endtask

  // Apply controls for one edge, then queue the outputs expected after that edge.
  task automatic cyc(input logic [5:0] c, input logic [5:0] ba,
                     input logic [5:0] epc, input logic efl, input logic eer);
    {PCincr, PCabsbranch, PCrelbranch, stall, call, ret} = c;
    Branchaddr = ba;
    @(posedge clk);
    #1;
    push_exp(epc, 1'b1, efl, eer);
  endtask

  // Short reset pulse between edges; the following edge leaves BOOT.
  task automatic areset();
    @(negedge clk);
    #1;
    {PCincr, PCabsbranch, PCrelbranch, stall, call, ret} = C_NONE;
    Branchaddr = '0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(6'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    push_exp(6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    push_exp(6'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    cyc(C_INC | C_STL, 6'd0, 6'd0, 1'b0, 1'b0);
    for (int i = 1; i < 64; i++) cyc(C_INC, 6'd0, 6'(i), 1'b0, 1'b0);
    cyc(C_INC, 6'd0, 6'd0, 1'b0, 1'b0);

    cyc(C_ABS, 6'd10, 6'd10, 1'b1, 1'b0);
    cyc(C_NONE, 6'd0, 6'd10, 1'b0, 1'b0);
    cyc(C_REL, 6'b111101, 6'd7, 1'b1, 1'b0);
    cyc(C_NONE, 6'd0, 6'd7, 1'b0, 1'b0);
    cyc(C_ABS, 6'd5, 6'd5, 1'b1, 1'b0);
    cyc(C_ABS | C_INC, 6'd40, 6'd40, 1'b1, 1'b0);
    cyc(C_NONE, 6'd0, 6'd40, 1'b0, 1'b0);
    cyc(C_REL | C_INC, 6'd2, 6'd42, 1'b1, 1'b0);
    cyc(C_ABS, 6'd62, 6'd62, 1'b1, 1'b0);
    cyc(C_REL, 6'd5, 6'd3, 1'b1, 1'b0);
    cyc(C_INC | C_STL, 6'd0, 6'd3, 1'b0, 1'b0);
    cyc(C_INC | C_STL, 6'd0, 6'd3, 1'b0, 1'b0);
    cyc(C_INC | C_STL, 6'd0, 6'd3, 1'b0, 1'b0);
    cyc(C_INC, 6'd0, 6'd4, 1'b0, 1'b0);
    cyc(C_ABS | C_STL, 6'd50, 6'd4, 1'b0, 1'b0);
    cyc(C_NONE, 6'd0, 6'd4, 1'b0, 1'b0);

`ifdef PC_RAS_EN
    cyc(C_ABS, 6'd8, 6'd8, 1'b1, 1'b0);
    cyc(C_CAL, 6'd20, 6'd20, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd9, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd0, 1'b1, 1'b1);
    cyc(C_INC, 6'd0, 6'd1, 1'b0, 1'b1);
    areset();

    cyc(C_INC, 6'd0, 6'd1, 1'b0, 1'b0);
    cyc(C_CAL, 6'd2, 6'd2, 1'b1, 1'b0);
    cyc(C_CAL, 6'd3, 6'd3, 1'b1, 1'b0);
    cyc(C_CAL, 6'd4, 6'd4, 1'b1, 1'b0);
    cyc(C_CAL, 6'd5, 6'd5, 1'b1, 1'b0);
    cyc(C_CAL, 6'd30, 6'd30, 1'b1, 1'b0);
    cyc(C_RET | C_STL, 6'd0, 6'd30, 1'b0, 1'b0);
    cyc(C_RET, 6'd0, 6'd6, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd5, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd4, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd3, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd0, 1'b1, 1'b1);
    areset();

    cyc(C_CAL, 6'd20, 6'd20, 1'b1, 1'b0);
    cyc(C_CAL | C_RET, 6'd40, 6'd1, 1'b1, 1'b0);
    cyc(C_RET, 6'd0, 6'd0, 1'b1, 1'b1);
`else
    cyc(C_CAL, 6'd20, 6'd20, 1'b1, 1'b0);
    cyc(C_RET | C_INC, 6'd0, 6'd21, 1'b0, 1'b0);
    cyc(C_RET, 6'd0, 6'd21, 1'b0, 1'b0);
    cyc(C_CAL | C_RET, 6'd33, 6'd33, 1'b1, 1'b0);
`endif
    areset();
    cyc(C_INC, 6'd0, 6'd1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
